// File: rtl/nonce_tx_arbiter.sv
// Round-robin capture of per-core golden nonces into a FIFO, drained one word at a time
// into the shared serial transmitter. Optional feature: NONCE_DEDUP_EN drops repeat nonces.
module nonce_tx_arbiter #(
    parameter int SLAVES     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int BUSY_TMO   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SLAVES-1:0]      nonce_valid,
    input  logic [32*SLAVES-1:0]   nonces,
    input  logic                   serial_busy,
    output logic                   serial_send,
    output logic [31:0]            golden_nonce,
    output logic                   new_nonce,
    output logic [FIFO_AW:0]       fifo_level,
    output logic                   overflow,
    output logic [2:0]             dbg_state
);

    localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [SLAVES-1:0] pend_q, pend_d, grant_oh;
    logic [31:0]       pend_nonce_q [SLAVES];
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d, grant_idx;
    logic              grant_vld;
    logic              overflow_q, overflow_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]  count_q, count_d;
    logic              fifo_full, fifo_empty, push, pop;
    logic [31:0]       fifo_head;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [31:0]       golden_q, golden_d;
    logic              dup;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= SLAVES) s = s - SLAVES;
        return PW'(s);
    endfunction

    assign fifo_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign push       = grant_vld;
    assign pop        = (state_q == S_LOAD);

    // First pending core at or after rr_ptr wins; a full FIFO stalls the grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int k = 0; k < SLAVES; k++) begin
            if (!grant_vld && !fifo_full && pend_q[wrap_add(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr_q, k);
            end
        end
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        pend_d     = (pend_q & ~grant_oh) | nonce_valid;
        overflow_d = overflow_q | (|(nonce_valid & pend_q & ~grant_oh));
        rr_ptr_d   = grant_vld ? wrap_add(grant_idx, 1) : rr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        tmo_d    = tmo_q;
        golden_d = golden_q;
        if (state_q == S_SEND)         tmo_d = '0;
        else if (state_q == S_WAIT_HI) tmo_d = tmo_q + 1'b1;
        if (state_q == S_LOAD && !dup) golden_d = fifo_head;
    end

`ifdef NONCE_DEDUP_EN
    logic sent_vld_q;
    assign dup = sent_vld_q && (fifo_head == golden_q);
    always_ff @(posedge clk) begin
        if (rst)                             sent_vld_q <= 1'b0;
        else if (state_q == S_LOAD && !dup)  sent_vld_q <= 1'b1;
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            golden_q   <= '0;
        end else begin
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            golden_q   <= golden_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage only; validity is tracked by pend_q and the FIFO pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLAVES; i++) begin
            if (nonce_valid[i]) pend_nonce_q[i] <= nonces[32*i +: 32];
        end
        if (push) fifo_mem_q[wr_ptr_q] <= pend_nonce_q[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Transmit handshake: serial_send is a one-cycle request; the transmitter answers by
    // raising serial_busy, and the word is done once busy falls (or never rose in time).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!fifo_empty) state_d = S_LOAD;
            S_LOAD:    state_d = dup ? S_IDLE : S_SEND;
            S_SEND:    state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (serial_busy)                      state_d = S_WAIT_LO;
                else if (tmo_q == TW'(BUSY_TMO - 1))  state_d = S_IDLE;
            end
            S_WAIT_LO: if (!serial_busy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        serial_send = (state_q == S_SEND);
        new_nonce   = (state_q == S_SEND);
        dbg_state   = state_q;
    end

    assign golden_nonce = golden_q;
    assign fifo_level   = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Bench for nonce_tx_arbiter: directed scenarios plus randomized traffic, all compared
// against a queue-based reference model of capture, arbitration and transmit sequencing.
module tb_nonce_tx_arbiter;

    localparam int SLAVES     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
    localparam int BUSY_TMO   = 15;
`ifdef NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    localparam int P_IDLE = 0, P_LOAD = 1, P_SEND = 2, P_WHI = 3, P_WLO = 4;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [SLAVES-1:0]    nonce_valid = '0;
    logic [32*SLAVES-1:0] nonces = '0;
    logic                 serial_busy;
    logic                 man_busy = 1'b0, auto_busy = 1'b0, auto_mode = 1'b0;
    logic                 serial_send, new_nonce, overflow;
    logic [31:0]          golden_nonce;
    logic [FIFO_AW:0]     fifo_level;
    logic [2:0]           dbg_state;

    assign serial_busy = auto_mode ? auto_busy : man_busy;

    always #5 clk = ~clk;

    nonce_tx_arbiter #(
        .SLAVES(SLAVES), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW), .BUSY_TMO(BUSY_TMO)
    ) dut (
        .clk(clk), .rst(rst), .nonce_valid(nonce_valid), .nonces(nonces),
        .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
        .new_nonce(new_nonce), .fifo_level(fifo_level), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          send_cnt = 0;
    bit          chk_on   = 1'b0;
    bit          sb_on    = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [SLAVES-1:0] m_pend = '0;
    logic [31:0]     m_pend_nonce [SLAVES];
    logic [31:0]     m_fifo[$];
    int              m_rr = 0, m_phase = P_IDLE, m_wait = 0;
    logic [31:0]     m_golden = '0, m_last = '0;
    bit              m_ovf = 1'b0, m_last_vld = 1'b0;

    always @(posedge clk) begin : model_b
        int          sz, r0, j;
        bit          found;
        logic [31:0] head;
        if (rst) begin
            m_pend = '0; m_fifo.delete(); m_rr = 0; m_phase = P_IDLE; m_wait = 0;
            m_golden = '0; m_ovf = 1'b0; m_last_vld = 1'b0;
        end else begin
            sz = m_fifo.size();
            case (m_phase)
                P_IDLE: if (sz > 0) m_phase = P_LOAD;
                P_LOAD: begin
                    head = m_fifo.pop_front();
                    if (DEDUP && m_last_vld && head == m_last) m_phase = P_IDLE;
                    else begin
                        m_golden = head; m_last = head; m_last_vld = 1'b1; m_phase = P_SEND;
                    end
                end
                P_SEND: begin m_phase = P_WHI; m_wait = 0; end
                P_WHI: begin
                    if (serial_busy) m_phase = P_WLO;
                    else begin
                        m_wait++;
                        if (m_wait == BUSY_TMO) m_phase = P_IDLE;
                    end
                end
                P_WLO: if (!serial_busy) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
            found = 1'b0;
            r0 = m_rr;
            if (sz < FIFO_DEPTH) begin
                for (int k = 0; k < SLAVES; k++) begin
                    j = (r0 + k) % SLAVES;
                    if (!found && m_pend[j]) begin
                        found = 1'b1;
                        m_fifo.push_back(m_pend_nonce[j]);
                        m_pend[j] = 1'b0;
                        m_rr = (j + 1) % SLAVES;
                    end
                end
            end
            for (int i = 0; i < SLAVES; i++) begin
                if (nonce_valid[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend_nonce[i] = nonces[32*i +: 32];
                    m_pend[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("serial_send", serial_send, m_phase == P_SEND);
            check("new_nonce", new_nonce, m_phase == P_SEND);
            check("golden_nonce", golden_nonce, m_golden);
            check("fifo_level", fifo_level, m_fifo.size());
            check("overflow", overflow, m_ovf);
            if (serial_send) begin
                send_cnt++;
                if (sb_on) begin
                    if (exp_q.size() == 0) check("sb_unexpected_send", 1, 0);
                    else check("sb_order", golden_nonce, exp_q.pop_front());
                end
            end
        end
    end

    // Transmitter emulation: busy rises after a short delay, occasionally never.
    int aw = 0, al = 0;
    always @(negedge clk) begin
        if (serial_send) begin
            aw = $urandom_range(0, 3);
            al = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
        end
        if (aw > 0) begin auto_busy = 1'b0; aw--; end
        else if (al > 0) begin auto_busy = 1'b1; al--; end
        else auto_busy = 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst = 1'b1; nonce_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(m_fifo.size() == 0 && m_pend == '0 && m_phase == P_IDLE) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_budget", n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, k_send, s0;
        logic [31:0] a [SLAVES];
        logic [31:0] b0;

        @(negedge clk);
        chk_on = 1'b1;
        check("rst_serial_send", serial_send, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state_idle", dbg_state, 0);
        rst = 1'b0;

        // 1: single nonce, latency 4
        @(negedge clk);
        nonce_valid = 4'b0001;
        nonces[31:0] = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            nonce_valid = '0;
            check("t1_latency", serial_send, k == 4);
        end
        check("t1_golden", golden_nonce, 32'hDEADBEEF);
        check("t1_new_nonce", new_nonce, 1);
        man_busy = 1'b1;
        repeat (20) @(negedge clk);
        man_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_idle", dbg_state, 0);
        check("t1_level", fifo_level, 0);

        // 2: simultaneous capture, round-robin order, grant/capture collision
        reset_dut();
        auto_mode = 1'b1;
        for (int i = 0; i < SLAVES; i++) a[i] = $urandom;
        b0 = $urandom;
        for (int i = 0; i < SLAVES; i++) exp_q.push_back(a[i]);
        exp_q.push_back(b0);
        sb_on = 1'b1;
        @(negedge clk);
        nonce_valid = '1;
        for (int i = 0; i < SLAVES; i++) nonces[32*i +: 32] = a[i];
        @(negedge clk);
        nonce_valid = 4'b0001;
        nonces[31:0] = b0;
        @(negedge clk);
        nonce_valid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check("t2_all_sent", exp_q.size(), 0);
        sb_on = 1'b0;
        exp_q.delete();
        drain(200);
        check("t2_overflow", overflow, 0);

        // 3: FIFO saturation with backpressure, then overwrite
        auto_mode = 1'b0;
        man_busy = 1'b1;
        for (int t = 0; t < 12; t++) begin
            nonce_valid = '0;
            nonce_valid[t % SLAVES] = 1'b1;
            nonces[32*(t % SLAVES) +: 32] = 32'hC000_0000 + t;
            @(negedge clk);
        end
        nonce_valid = '0;
        repeat (4) @(negedge clk);
        check("t3_level_full", fifo_level, FIFO_DEPTH);
        check("t3_no_overflow", overflow, 0);
        nonce_valid = 4'b0010;
        nonces[63:32] = 32'hC0DE_0001;
        @(negedge clk);
        nonce_valid = '0;
        @(negedge clk);
        check("t3_overflow", overflow, 1);
        s0 = send_cnt;
        man_busy = 1'b0;
        auto_mode = 1'b1;
        drain(1000);
        check("t3_sent_after_release", send_cnt - s0, FIFO_DEPTH + 3);

        // 4: busy never rises
        auto_mode = 1'b0;
        man_busy = 1'b0;
        nonce_valid = 4'b0011;
        nonces[31:0] = 32'h4444_0000;
        nonces[63:32] = 32'h4444_0001;
        @(negedge clk);
        nonce_valid = '0;
        n = 0;
        while (!serial_send && n < 20) begin @(negedge clk); n++; end
        check("t4_first_send", serial_send, 1);
        k_send = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == BUSY_TMO) check("t4_still_waiting", dbg_state == 3'd0, 0);
            if (k == BUSY_TMO + 1) check("t4_timeout_idle", dbg_state == 3'd0, 1);
            if (serial_send && k_send < 0) k_send = k;
        end
        check("t4_next_send", k_send, BUSY_TMO + 3);
        drain(200);

        // 5: reset while waiting for busy to fall with 3 entries queued
        man_busy = 1'b1;
        nonce_valid = '1;
        for (int i = 0; i < SLAVES; i++) nonces[32*i +: 32] = 32'h5555_0000 + i;
        @(negedge clk);
        nonce_valid = '0;
        n = 0;
        while (m_phase != P_WLO && n < 30) begin @(negedge clk); n++; end
        check("t5_queued", fifo_level, 3);
        rst = 1'b1;
        @(negedge clk);
        check("t5_send", serial_send, 0);
        check("t5_new_nonce", new_nonce, 0);
        check("t5_golden", golden_nonce, 0);
        check("t5_level", fifo_level, 0);
        check("t5_overflow", overflow, 0);
        check("t5_idle", dbg_state, 0);
        rst = 1'b0;
        man_busy = 1'b0;
        s0 = send_cnt;
        repeat (30) @(negedge clk);
        check("t5_no_send", send_cnt - s0, 0);

        // 6: same nonce twice
        auto_mode = 1'b1;
        s0 = send_cnt;
        for (int r = 0; r < 2; r++) begin
            nonce_valid = 4'b0100;
            nonces[95:64] = 32'h0000_1234;
            @(negedge clk);
            nonce_valid = '0;
            drain(200);
        end
        check("t6_repeat_sends", send_cnt - s0, DEDUP ? 1 : 2);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < SLAVES; i++) begin
                nonce_valid[i] = ($urandom_range(0, 4) == 0);
                nonces[32*i +: 32] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        nonce_valid = '0;
        drain(2000);
        check("final_level", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
